// File: rtl/multicycle_control.sv
// Multi-cycle CPU control unit: IF/ID/EXE/MEM/WB sequencer with ALU/operand decode and retire counter.
// Optional build macro MCCTRL_ILLEGAL_TRAP_EN: illegal opcodes halt the machine instead of retiring as NOPs.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             sign,
  output logic [2:0]       state,
  output logic [2:0]       ALUopcode,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             DBDataSrc,
  output logic [1:0]       PCSrc,
  output logic             PCWre,
  output logic             IRWre,
  output logic             RegWre,
  output logic             mRD,
  output logic             mWR,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLLI  = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_CMPS = 3'b110;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;

  logic is_rtype, is_ialu, is_lw, is_sw, is_beq, is_bltz;
  logic is_j, is_jr, is_jal, is_halt, is_jump, is_branch, is_legal;

  assign is_rtype  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
                     (opcode == OP_OR)  || (opcode == OP_SLT);
  assign is_ialu   = (opcode == OP_ADDIU) || (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                     (opcode == OP_SLLI)  || (opcode == OP_SLTI);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_bltz   = (opcode == OP_BLTZ);
  assign is_j      = (opcode == OP_J);
  assign is_jr     = (opcode == OP_JR);
  assign is_jal    = (opcode == OP_JAL);
  assign is_halt   = (opcode == OP_HALT);
  assign is_jump   = is_j || is_jr || is_jal;
  assign is_branch = is_beq || is_bltz;
  assign is_legal  = is_rtype || is_ialu || is_lw || is_sw || is_branch || is_jump || is_halt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID: begin
        if (is_jump)        state_d = S_IF;
        else if (is_halt)   state_d = S_HALT;
        else if (!is_legal) begin
`ifdef MCCTRL_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_IF;
`endif
        end
        else                state_d = S_EXE;
      end
      S_EXE: begin
        if (is_branch)          state_d = S_IF;
        else if (is_lw || is_sw) state_d = S_MEM;
        else                    state_d = S_WB;
      end
      S_MEM:  state_d = is_lw ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // The instruction retires on the cycle that hands control back to IF.
  assign PCWre  = nRST && (state_q != S_HALT) && (state_d == S_IF);
  assign IRWre  = nRST && (state_q == S_IF);
  assign RegWre = nRST && ((state_q == S_WB) || ((state_q == S_ID) && is_jal));
  assign mRD    = nRST && (state_q == S_MEM) && is_lw;
  assign mWR    = nRST && (state_q == S_MEM) && is_sw;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (PCWre) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    PCSrc = 2'b00;
    if (is_j || is_jal)               PCSrc = 2'b11;
    else if (is_jr)                   PCSrc = 2'b10;
    else if (is_beq && zero)          PCSrc = 2'b01;
    else if (is_bltz && sign)         PCSrc = 2'b01;
  end

  always_comb begin
    ALUopcode = ALU_ADD;
    case (opcode)
      OP_SUB, OP_BEQ, OP_BLTZ: ALUopcode = ALU_SUB;
      OP_AND, OP_ANDI:         ALUopcode = ALU_AND;
      OP_OR, OP_ORI:           ALUopcode = ALU_OR;
      OP_SLLI:                 ALUopcode = ALU_SLL;
      OP_SLT, OP_SLTI:         ALUopcode = ALU_CMPS;
      default:                 ALUopcode = ALU_ADD;
    endcase
  end

  always_comb begin
    RegDst = 2'b01;
    if (is_jal)        RegDst = 2'b00;
    else if (is_rtype) RegDst = 2'b10;
  end

  assign ALUSrcA   = (opcode == OP_SLLI);
  assign ALUSrcB   = (opcode == OP_ADDIU) || (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                     (opcode == OP_SLTI)  || is_lw || is_sw;
  assign ExtSel    = !((opcode == OP_ANDI) || (opcode == OP_ORI));
  assign WrRegDSrc = !is_jal;
  assign DBDataSrc = is_lw;

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model checked every cycle, plus directed literal checks.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [5:0]  opcode = 6'b000000;
  logic        zero = 1'b0;
  logic        sign = 1'b0;
  logic [2:0]  state, ALUopcode;
  logic        ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc;
  logic [1:0]  RegDst, PCSrc;
  logic        PCWre, IRWre, RegWre, mRD, mWR, halted;
  logic [31:0] retired;

  int npass = 0;
  int nchk  = 0;

  multicycle_control #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .opcode(opcode), .zero(zero), .sign(sign),
    .state(state), .ALUopcode(ALUopcode), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .PCSrc(PCSrc), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD),
    .mWR(mWR), .halted(halted), .retired(retired)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else npass++;
  endtask

  // Instruction-level rules: cycle count, halting, and decode tables by opcode.
  function automatic bit is_rtype(input logic [5:0] op);
    return op inside {6'b000000, 6'b000001, 6'b010000, 6'b010011, 6'b100110};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                      6'b010011, 6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001,
                      6'b110100, 6'b110110, 6'b111000, 6'b111001, 6'b111010, 6'b111111};
  endfunction

  function automatic bit halts(input logic [5:0] op);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    return (op == 6'b111111) || !is_legal(op);
`else
    return (op == 6'b111111);
`endif
  endfunction

  function automatic int cpi(input logic [5:0] op);
    if (op == 6'b110001) return 5;
    if (op inside {6'b110100, 6'b110110}) return 3;
    if (op inside {6'b111000, 6'b111001, 6'b111010, 6'b111111} || !is_legal(op)) return 2;
    return 4;
  endfunction

  // Phase k of an instruction maps to IF, ID, EXE, then MEM (memory ops) or WB, then WB.
  function automatic logic [2:0] stage(input logic [5:0] op, input int k);
    case (k)
      0: return 3'd0;
      1: return 3'd1;
      2: return 3'd2;
      3: return (op inside {6'b110000, 6'b110001}) ? 3'd3 : 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] op);
    case (op)
      6'b000001, 6'b110100, 6'b110110: return 3'b001;
      6'b010000, 6'b010001:            return 3'b100;
      6'b010011, 6'b010010:            return 3'b011;
      6'b011000:                       return 3'b010;
      6'b100110, 6'b100111:            return 3'b110;
      default:                         return 3'b000;
    endcase
  endfunction

  int          m_k = 0;
  bit          m_halt = 0;
  logic [31:0] m_ret = 0;
  bit          started = 0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_k <= 0; m_halt <= 0; m_ret <= 0;
    end else if (!m_halt) begin
      if (m_k == 1 && halts(opcode)) m_halt <= 1;
      else if (m_k == cpi(opcode) - 1) begin
        m_k <= 0; m_ret <= m_ret + 1;
      end else m_k <= m_k + 1;
    end
  end

  logic [2:0] e_st;
  logic       e_pcw, e_irw, e_rw, e_rd, e_wr;
  logic [1:0] e_pcsrc;

  always @(negedge CLK) begin
    if (started) begin
      e_st  = m_halt ? 3'd5 : stage(opcode, m_k);
      e_pcw = nRST && !m_halt && (m_k == cpi(opcode) - 1) && !halts(opcode);
      e_irw = nRST && !m_halt && (m_k == 0);
      e_rw  = nRST && !m_halt && ((e_st == 3'd4) || (e_st == 3'd1 && opcode == 6'b111010));
      e_rd  = nRST && !m_halt && (e_st == 3'd3) && (opcode == 6'b110001);
      e_wr  = nRST && !m_halt && (e_st == 3'd3) && (opcode == 6'b110000);
      chk("state", state, e_st);
      chk("halted", halted, m_halt);
      chk("retired", retired, m_ret);
      chk("PCWre", PCWre, e_pcw);
      chk("IRWre", IRWre, e_irw);
      chk("RegWre", RegWre, e_rw);
      chk("mRD", mRD, e_rd);
      chk("mWR", mWR, e_wr);
      chk("ALUopcode", ALUopcode, alu_of(opcode));
      chk("ALUSrcA", ALUSrcA, opcode == 6'b011000);
      chk("ALUSrcB", ALUSrcB, opcode inside {6'b000010, 6'b010001, 6'b010010, 6'b100111, 6'b110001, 6'b110000});
      chk("ExtSel", ExtSel, !(opcode inside {6'b010001, 6'b010010}));
      chk("DBDataSrc", DBDataSrc, opcode == 6'b110001);
      if (e_rw) begin
        chk("RegDst", RegDst, (opcode == 6'b111010) ? 2'b00 : (is_rtype(opcode) ? 2'b10 : 2'b01));
        chk("WrRegDSrc", WrRegDSrc, opcode != 6'b111010);
      end
      if (e_pcw) begin
        if (opcode inside {6'b111000, 6'b111010}) e_pcsrc = 2'b11;
        else if (opcode == 6'b111001) e_pcsrc = 2'b10;
        else if ((opcode == 6'b110100 && zero) || (opcode == 6'b110110 && sign)) e_pcsrc = 2'b01;
        else e_pcsrc = 2'b00;
        chk("PCSrc", PCSrc, e_pcsrc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic z, input logic s, input int n);
    opcode = op; zero = z; sign = s;
    cyc(n);
  endtask

  initial begin
    nRST = 1'b0;
    started = 1;
    cyc(2);
    chk("rst_state", state, 3'b000);
    chk("rst_retired", retired, 0);
    chk("rst_IRWre", IRWre, 0);
    nRST = 1'b1;

    instr(6'b000000, 0, 0, 4);
    chk("add_retired", retired, 1);

    instr(6'b110001, 0, 0, 3);
    chk("lw_mem_state", state, 3'b011);
    chk("lw_mRD", mRD, 1);
    cyc(2);
    chk("lw_retired", retired, 2);

    instr(6'b110100, 1, 0, 2);
    chk("beq_taken_PCSrc", PCSrc, 2'b01);
    chk("beq_taken_PCWre", PCWre, 1);
    cyc(1);
    instr(6'b110100, 0, 0, 3);
    instr(6'b110110, 0, 1, 3);
    chk("branch_retired", retired, 5);

    instr(6'b111010, 0, 0, 1);
    chk("jal_RegWre", RegWre, 1);
    chk("jal_RegDst", RegDst, 2'b00);
    chk("jal_PCSrc", PCSrc, 2'b11);
    chk("jal_PCWre", PCWre, 1);
    cyc(1);
    chk("jal_next_IF", state, 3'b000);

    instr(6'b000001, 0, 0, 4);
    instr(6'b000010, 0, 0, 4);
    instr(6'b010000, 0, 0, 4);
    instr(6'b010001, 0, 0, 4);
    instr(6'b010010, 0, 0, 4);
    instr(6'b010011, 0, 0, 4);
    instr(6'b011000, 0, 0, 4);
    instr(6'b100110, 0, 0, 4);
    instr(6'b100111, 0, 0, 4);
    instr(6'b111000, 0, 0, 2);
    instr(6'b111001, 0, 0, 2);
    instr(6'b110110, 0, 0, 3);
    instr(6'b110000, 0, 0, 4);
    chk("mix_retired", retired, 19);

    instr(6'b111111, 0, 0, 2);
    chk("halt_state", state, 3'b101);
    chk("halt_halted", halted, 1);
    cyc(10);
    chk("halt_retired", retired, 19);

    nRST = 1'b0;
    cyc(1);
    nRST = 1'b1;
    instr(6'b110000, 0, 0, 3);
    chk("sw_mWR", mWR, 1);
    nRST = 1'b0;
    #1;
    chk("rst_mid_mWR", mWR, 0);
    chk("rst_mid_state", state, 3'b000);
    chk("rst_mid_retired", retired, 0);
    cyc(2);
    nRST = 1'b1;

    instr(6'b000000, 0, 0, 4);
    instr(6'b101010, 0, 0, 2);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    chk("illegal_halted", halted, 1);
    chk("illegal_retired", retired, 1);
`else
    chk("illegal_halted", halted, 0);
    chk("illegal_retired", retired, 2);
`endif
    cyc(3);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
